// File: rtl/sram_responder_pkg.sv
// Shared constants and FSM encoding for the SRAM responder.
package sram_responder_pkg;

  localparam int unsigned DefWidth = 4;
  localparam int unsigned DefDepth = 16;
  localparam int unsigned DefAw    = 4;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StWrite = 2'd1,
    StRead  = 2'd2
  } state_e;

endpackage

// File: rtl/sram_responder_addr_counter.sv
// Wrapping address counter, advanced by one on each count strobe.
module sram_responder_addr_counter #(
  parameter int unsigned Aw = 4
) (
  input  logic          clock_i,
  input  logic          reset_i,
  input  logic          count_i,
  output logic [Aw-1:0] addr_o
);

  logic [Aw-1:0] addr_q;
  logic [Aw-1:0] addr_d;

  always_comb begin
    addr_d = addr_q;
    if (count_i) begin
      addr_d = addr_q + Aw'(1);
    end
  end

  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      addr_q <= '0;
    end else begin
      addr_q <= addr_d;
    end
  end

  assign addr_o = addr_q;

endmodule

// File: rtl/sram_responder.sv
// Memory-side responder for the SRAM strobe interface: register-array storage,
// write holding register, address counter and strobe-decoding FSM.
module sram_responder
  import sram_responder_pkg::*;
#(
  parameter int unsigned Width = DefWidth,
  parameter int unsigned Depth = DefDepth,
  parameter int unsigned Aw    = DefAw
) (
  input  logic             clock_i,
  input  logic             reset_i,
  input  logic             count_i,
  input  logic             latch_i,
  input  logic             de_i,
  input  logic             n_ce_i,
  input  logic             n_oe_i,
  input  logic             n_we_i,
  input  logic [Width-1:0] data_in_i,
  output logic [Width-1:0] data_out_o,
  output logic             data_oe_o,
  output logic [Aw-1:0]    addr_o,
  output logic             write_done_o,
  output logic             conflict_o
);

  state_e           state_q;
  logic [Width-1:0] hold_q;
  logic [Width-1:0] mem_q [Depth];
  logic [Width-1:0] data_out_q;
  logic             data_oe_q;
  logic             write_done_q;
  logic             conflict_q;
  logic [Aw-1:0]    addr;

  logic sel;
  logic wr_req;
  logic rd_req;
  logic commit;

  sram_responder_addr_counter #(
    .Aw(Aw)
  ) u_addr_counter (
    .clock_i(clock_i),
    .reset_i(reset_i),
    .count_i(count_i),
    .addr_o (addr)
  );

  assign sel    = ~n_ce_i;
  assign wr_req = sel & ~n_we_i;
  assign rd_req = sel & ~n_oe_i & n_we_i;
  // Exactly one commit per n_we low pulse: only on the edge that enters StWrite.
  assign commit = wr_req & (state_q != StWrite);

  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      hold_q <= '0;
    end else if (latch_i && de_i) begin
      hold_q <= data_in_i;
    end
  end

  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      for (int unsigned i = 0; i < Depth; i++) begin
        mem_q[i] <= '0;
      end
    end else if (commit) begin
      mem_q[addr] <= hold_q;
    end
  end

  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      state_q      <= StIdle;
      data_out_q   <= '0;
      data_oe_q    <= 1'b0;
      write_done_q <= 1'b0;
      conflict_q   <= 1'b0;
    end else begin
      write_done_q <= commit;
      if (wr_req && !n_oe_i) begin
        conflict_q <= 1'b1;
      end
      unique case (state_q)
        StIdle: begin
          if (wr_req) begin
            state_q   <= StWrite;
            data_oe_q <= 1'b0;
          end else if (rd_req) begin
            state_q    <= StRead;
            data_out_q <= mem_q[addr];
            data_oe_q  <= 1'b1;
          end else begin
            data_oe_q <= 1'b0;
          end
        end
        StWrite: begin
          state_q   <= wr_req ? StWrite : StIdle;
          data_oe_q <= 1'b0;
        end
        StRead: begin
          if (wr_req) begin
            state_q   <= StWrite;
            data_oe_q <= 1'b0;
          end else if (rd_req) begin
            data_out_q <= mem_q[addr];
            data_oe_q  <= 1'b1;
          end else begin
            state_q   <= StIdle;
            data_oe_q <= 1'b0;
          end
        end
        default: begin
          state_q   <= StIdle;
          data_oe_q <= 1'b0;
        end
      endcase
    end
  end

  assign data_out_o   = data_out_q;
  assign data_oe_o    = data_oe_q;
  assign addr_o       = addr;
  assign write_done_o = write_done_q;
  assign conflict_o   = conflict_q;

endmodule
